wash_sequencer: RTL and testbench

Parametrised washing-machine program sequencer: runs a selectable wash/rinse/spin program with per-phase second timers, a weight-scaled fill/drain time, a configurable rinse repeat count, pause/resume, and an end-of-cycle buzzer. It sits between the debounced front-panel pulse inputs and the LED/valve/motor/display drivers. It replaces the untimed one-clock-per-state controller.

---
 rtl/wash_sequencer.sv | 227 ++++++++++++++++++++++
 tb/tb_wash_sequencer.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wash_sequencer.sv
// rtl/wash_sequencer.sv - timed wash/rinse/spin program sequencer with pause and buzzer
module wash_sequencer #(
  parameter int TICK_DIV = 50_000_000,
  parameter int CNT_W    = 8,
  parameter int T_FILL   = 10,
  parameter int T_DRAIN  = 6,
  parameter int T_WASH   = 30,
  parameter int T_RINSE  = 15,
  parameter int T_SPIN   = 12,
  parameter int N_RINSE  = 2,
  parameter int T_BUZZ   = 3
) (
  input  logic             clk_N,
  input  logic             rst,
  input  logic             start_pause,
  input  logic             mode_next,
  input  logic             weight_next,
  output logic             running,
  output logic             paused,
  output logic             light_xi,
  output logic             light_piao,
  output logic             light_tuo,
  output logic             valve_in,
  output logic             valve_out,
  output logic             motor,
  output logic             buzzer,
  output logic [2:0]       status_mode,
  output logic [1:0]       status_weight,
  output logic [3:0]       phase,
  output logic [CNT_W-1:0] rem_sec,
  output logic [2:0]       rinse_left
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    FILL_W  = 4'd1,
    WASH    = 4'd2,
    DRAIN_R = 4'd3,
    SPIN_R  = 4'd4,
    FILL_R  = 4'd5,
    RINSE   = 4'd6,
    DRAIN_S = 4'd7,
    SPIN    = 4'd8,
    DONE    = 4'd9
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       mode_q, mode_d;
  logic [1:0]       weight_q, weight_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [2:0]       rinse_q, rinse_d;
  logic             paused_q, paused_d;
  logic             xi_q, xi_d, piao_q, piao_d, tuo_q, tuo_d;
  logic             running_q, running_d;
  logic             vin_q, vin_d, vout_q, vout_d, motor_q, motor_d, buzz_q, buzz_d;
  logic             entering;

  function automatic logic has_wash(logic [2:0] m);
    return m <= 3'd2;
  endfunction

  function automatic logic has_rinse(logic [2:0] m);
    return (m == 3'd0) || (m == 3'd1) || (m == 3'd3) || (m == 3'd4);
  endfunction

  function automatic logic has_spin(logic [2:0] m);
    return (m == 3'd0) || (m == 3'd3) || (m == 3'd5);
  endfunction

  function automatic logic [CNT_W-1:0] phase_dur(state_t s, logic [1:0] w);
    logic [CNT_W-1:0] scale;
    scale = CNT_W'(w) + CNT_W'(1);
    case (s)
      FILL_W, FILL_R:   phase_dur = CNT_W'(T_FILL) * scale;
      DRAIN_R, DRAIN_S: phase_dur = CNT_W'(T_DRAIN) * scale;
      WASH:             phase_dur = CNT_W'(T_WASH);
      RINSE:            phase_dur = CNT_W'(T_RINSE);
      SPIN_R, SPIN:     phase_dur = CNT_W'(T_SPIN);
      DONE:             phase_dur = CNT_W'(T_BUZZ);
      default:          phase_dur = '0;
    endcase
  endfunction

  function automatic state_t first_phase(logic [2:0] m);
    if (has_wash(m)) return FILL_W;
    if (has_rinse(m)) return DRAIN_R;
    return DRAIN_S;
  endfunction

  // rinse_left already counts the pass in progress, so zero at RINSE exit means the loop is over
  function automatic state_t next_phase(state_t s, logic [2:0] m, logic [2:0] r);
    case (s)
      FILL_W:  next_phase = WASH;
      WASH:    next_phase = has_rinse(m) ? DRAIN_R : (has_spin(m) ? DRAIN_S : DONE);
      DRAIN_R: next_phase = SPIN_R;
      SPIN_R:  next_phase = FILL_R;
      FILL_R:  next_phase = RINSE;
      RINSE:   next_phase = (r != 3'd0) ? DRAIN_R : (has_spin(m) ? DRAIN_S : DONE);
      DRAIN_S: next_phase = SPIN;
      SPIN:    next_phase = DONE;
      default: next_phase = IDLE;
    endcase
  endfunction

  // Next-state and next-output computation; the tick is resolved before the pause toggle
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    weight_d = weight_q;
    rem_d    = rem_q;
    presc_d  = presc_q;
    rinse_d  = rinse_q;
    paused_d = paused_q;
    xi_d     = xi_q;
    piao_d   = piao_q;
    tuo_d    = tuo_q;
    entering = 1'b0;
    if (state_q == IDLE) begin
      if (start_pause) begin
        state_d  = first_phase(mode_q);
        rinse_d  = 3'(N_RINSE);
        xi_d     = has_wash(mode_q);
        piao_d   = has_rinse(mode_q);
        tuo_d    = has_spin(mode_q);
        entering = 1'b1;
      end else begin
        if (mode_next) mode_d = (mode_q == 3'd5) ? 3'd0 : mode_q + 3'd1;
        if (weight_next) weight_d = weight_q + 2'd1;
      end
    end else begin
      if (!paused_q) begin
        if (presc_q == PRESC_MAX) begin
          presc_d = '0;
          rem_d   = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) begin
            state_d  = next_phase(state_q, mode_q, rinse_q);
            entering = 1'b1;
            if (state_q == WASH) xi_d = 1'b0;
            if ((state_q == RINSE) && (rinse_q == 3'd0)) piao_d = 1'b0;
            if (state_q == SPIN) tuo_d = 1'b0;
          end
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      if (start_pause && (state_q != DONE)) paused_d = !paused_q;
    end
    if (entering) begin
      presc_d = '0;
      rem_d   = phase_dur(state_d, weight_q);
      if (state_d == DRAIN_R) rinse_d = rinse_d - 3'd1;
    end
    // A pause cannot survive into DONE, where start_pause no longer toggles it
    if ((state_d == IDLE) || (state_d == DONE)) paused_d = 1'b0;
    if (state_d == IDLE) begin
      xi_d    = 1'b0;
      piao_d  = 1'b0;
      tuo_d   = 1'b0;
      rem_d   = '0;
      presc_d = '0;
    end
    running_d = (state_d != IDLE) && !paused_d;
    vin_d     = !paused_d && ((state_d == FILL_W) || (state_d == FILL_R));
    vout_d    = !paused_d && ((state_d == DRAIN_R) || (state_d == SPIN_R) ||
                              (state_d == DRAIN_S) || (state_d == SPIN));
    motor_d   = !paused_d && ((state_d == WASH) || (state_d == SPIN_R) ||
                              (state_d == RINSE) || (state_d == SPIN));
    buzz_d    = (state_d == DONE);
  end

  // State, timers and registered outputs
  always_ff @(posedge clk_N or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      mode_q    <= 3'd0;
      weight_q  <= 2'd0;
      rem_q     <= '0;
      presc_q   <= '0;
      rinse_q   <= 3'd0;
      paused_q  <= 1'b0;
      xi_q      <= 1'b0;
      piao_q    <= 1'b0;
      tuo_q     <= 1'b0;
      running_q <= 1'b0;
      vin_q     <= 1'b0;
      vout_q    <= 1'b0;
      motor_q   <= 1'b0;
      buzz_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      weight_q  <= weight_d;
      rem_q     <= rem_d;
      presc_q   <= presc_d;
      rinse_q   <= rinse_d;
      paused_q  <= paused_d;
      xi_q      <= xi_d;
      piao_q    <= piao_d;
      tuo_q     <= tuo_d;
      running_q <= running_d;
      vin_q     <= vin_d;
      vout_q    <= vout_d;
      motor_q   <= motor_d;
      buzz_q    <= buzz_d;
    end
  end

  assign running       = running_q;
  assign paused        = paused_q;
  assign light_xi      = xi_q;
  assign light_piao    = piao_q;
  assign light_tuo     = tuo_q;
  assign valve_in      = vin_q;
  assign valve_out     = vout_q;
  assign motor         = motor_q;
  assign buzzer        = buzz_q;
  assign status_mode   = mode_q;
  assign status_weight = weight_q;
  assign phase         = state_q;
  assign rem_sec       = rem_q;
  assign rinse_left    = rinse_q;

endmodule

// File: tb/tb_wash_sequencer.sv
// tb/tb_wash_sequencer.sv - randomized and directed bench for wash_sequencer against a schedule model
module tb_wash_sequencer;

  localparam int TDIV = 4;
  localparam int CW   = 8;
  localparam int TF   = 2;
  localparam int TD   = 1;
  localparam int TW   = 3;
  localparam int TR   = 2;
  localparam int TS   = 2;
  localparam int NR   = 2;
  localparam int TB   = 2;

  logic          clk;
  logic          rst;
  logic          start_pause, mode_next, weight_next;
  logic          running, paused, light_xi, light_piao, light_tuo;
  logic          valve_in, valve_out, motor, buzzer;
  logic [2:0]    status_mode;
  logic [1:0]    status_weight;
  logic [3:0]    phase;
  logic [CW-1:0] rem_sec;
  logic [2:0]    rinse_left;

  int total = 0;
  int bad   = 0;

  wash_sequencer #(
    .TICK_DIV(TDIV), .CNT_W(CW), .T_FILL(TF), .T_DRAIN(TD), .T_WASH(TW),
    .T_RINSE(TR), .T_SPIN(TS), .N_RINSE(NR), .T_BUZZ(TB)
  ) dut (
    .clk_N(clk), .rst(rst), .start_pause(start_pause), .mode_next(mode_next),
    .weight_next(weight_next), .running(running), .paused(paused),
    .light_xi(light_xi), .light_piao(light_piao), .light_tuo(light_tuo),
    .valve_in(valve_in), .valve_out(valve_out), .motor(motor), .buzzer(buzzer),
    .status_mode(status_mode), .status_weight(status_weight), .phase(phase),
    .rem_sec(rem_sec), .rinse_left(rinse_left)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Program schedule as a list of (phase code, seconds) segments
  function automatic int seg_phase(int mode, int idx);
    int q[$];
    if (mode <= 2) begin q.push_back(1); q.push_back(2); end
    if (mode != 2 && mode != 5)
      for (int r = 0; r < NR; r++) begin
        q.push_back(3); q.push_back(4); q.push_back(5); q.push_back(6);
      end
    if (mode == 0 || mode == 3 || mode == 5) begin q.push_back(7); q.push_back(8); end
    q.push_back(9);
    if (idx < q.size()) return q[idx];
    return 0;
  endfunction

  function automatic int seg_count(int mode);
    int n;
    n = 1;
    if (mode <= 2) n += 2;
    if (mode != 2 && mode != 5) n += 4 * NR;
    if (mode == 0 || mode == 3 || mode == 5) n += 2;
    return n;
  endfunction

  function automatic int seg_dur(int mode, int w, int idx);
    case (seg_phase(mode, idx))
      1, 5:    return TF * (w + 1);
      3, 7:    return TD * (w + 1);
      2:       return TW;
      6:       return TR;
      4, 8:    return TS;
      9:       return TB;
      default: return 0;
    endcase
  endfunction

  function automatic int seg_rin(int mode, int idx);
    int r;
    r = NR;
    for (int j = 0; j <= idx; j++) if (seg_phase(mode, j) == 3) r--;
    return r;
  endfunction

  function automatic bit pending(int mode, int idx, int lo, int hi);
    for (int j = idx; j < seg_count(mode); j++)
      if (seg_phase(mode, j) >= lo && seg_phase(mode, j) <= hi) return 1'b1;
    return 1'b0;
  endfunction

  // Model state: segment index plus unpaused cycles spent in it
  bit m_active, m_paused;
  int m_idx, m_el, m_mode, m_weight, m_rinse;

  always @(posedge clk or negedge rst) begin : model
    int idx, el, ph_before;
    bit act, pz;
    if (!rst) begin
      m_active <= 1'b0; m_paused <= 1'b0; m_idx <= 0; m_el <= 0;
      m_mode <= 0; m_weight <= 0; m_rinse <= 0;
    end else begin
      act = m_active; pz = m_paused; idx = m_idx; el = m_el;
      if (!act) begin
        if (start_pause) begin
          act = 1'b1; idx = 0; el = 0; pz = 1'b0;
        end else begin
          if (mode_next) m_mode <= (m_mode + 1) % 6;
          if (weight_next) m_weight <= (m_weight + 1) % 4;
        end
      end else begin
        ph_before = seg_phase(m_mode, idx);
        if (!pz) begin
          el++;
          if (el == seg_dur(m_mode, m_weight, idx) * TDIV) begin
            idx++; el = 0;
            if (idx >= seg_count(m_mode)) begin act = 1'b0; idx = 0; end
          end
        end
        if (start_pause && ph_before != 9) pz = !pz;
        if (!act || seg_phase(m_mode, idx) == 9) pz = 1'b0;
      end
      if (act) m_rinse <= seg_rin(m_mode, idx);
      m_active <= act; m_paused <= pz; m_idx <= idx; m_el <= el;
    end
  end

  int e_ph, e_rem;
  bit e_pz;
  logic [8:0] e_ctrl, a_ctrl;

  // Cycle-by-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (rst) begin
      e_ph  = m_active ? seg_phase(m_mode, m_idx) : 0;
      e_rem = m_active ? seg_dur(m_mode, m_weight, m_idx) - m_el / TDIV : 0;
      e_pz  = m_active && m_paused;
      e_ctrl = {m_active && !e_pz, e_pz,
                m_active && pending(m_mode, m_idx, 1, 2),
                m_active && pending(m_mode, m_idx, 3, 6),
                m_active && pending(m_mode, m_idx, 7, 8),
                !e_pz && (e_ph == 1 || e_ph == 5),
                !e_pz && (e_ph == 3 || e_ph == 4 || e_ph == 7 || e_ph == 8),
                !e_pz && (e_ph == 2 || e_ph == 4 || e_ph == 6 || e_ph == 8),
                e_ph == 9};
      a_ctrl = {running, paused, light_xi, light_piao, light_tuo,
                valve_in, valve_out, motor, buzzer};
      chk("cyc_phase", int'(phase), e_ph);
      chk("cyc_rem_sec", int'(rem_sec), e_rem);
      chk("cyc_rinse_left", int'(rinse_left), m_rinse);
      chk("cyc_ctrl", int'(a_ctrl), int'(e_ctrl));
      chk("cyc_status", int'({status_mode, status_weight}), m_mode * 4 + m_weight);
    end
  end

  int pcnt[16];
  int pseq[$];
  int rseq[$];
  int buzz_cyc, pause_cyc;
  bit tuo_spin, tuo_exit;

  task automatic pulse_mode(input int n);
    for (int i = 0; i < n; i++) begin
      mode_next = 1'b1; @(negedge clk);
      mode_next = 1'b0; @(negedge clk);
    end
  endtask

  task automatic pulse_weight(input int n);
    for (int i = 0; i < n; i++) begin
      weight_next = 1'b1; @(negedge clk);
      weight_next = 1'b0; @(negedge clk);
    end
  endtask

  // Start a program and record per-phase cycle counts until it returns to IDLE
  task automatic watch(input int action, input int budget);
    int prev, prev_r, wcnt, frozen, n, ph;
    bit acted, done;
    for (int i = 0; i < 16; i++) pcnt[i] = 0;
    pseq.delete(); rseq.delete();
    buzz_cyc = 0; pause_cyc = 0; tuo_spin = 1'b0; tuo_exit = 1'b1;
    prev = 0; prev_r = int'(rinse_left); wcnt = 0; frozen = -1; n = 0;
    acted = 1'b0; done = 1'b0;
    start_pause = 1'b1;
    while (!done) begin
      @(negedge clk);
      start_pause = 1'b0; weight_next = 1'b0;
      ph = int'(phase);
      if (ph == 0) begin
        done = 1'b1;
      end else begin
        n++;
        pcnt[ph]++;
        if (ph != prev) pseq.push_back(ph);
        if (int'(rinse_left) != prev_r) rseq.push_back(int'(rinse_left));
        if (buzzer) buzz_cyc++;
        if (ph == 8) tuo_spin = light_tuo;
        if (ph == 9 && prev == 8) tuo_exit = light_tuo;
        if (action == 1 && ph == 1 && !acted) begin
          weight_next = 1'b1; acted = 1'b1;
        end
        if (action == 2 && ph == 2) begin
          wcnt++;
          if (wcnt == 6 || wcnt == 16) start_pause = 1'b1;
          if (paused) begin
            pause_cyc++;
            chk("pause_motor", int'(motor), 0);
            if (frozen < 0) frozen = int'(rem_sec);
            else chk("pause_rem_frozen", int'(rem_sec), frozen);
          end
        end
        prev = ph; prev_r = int'(rinse_left);
        if (n > budget) begin
          chk("watch_budget", n, budget);
          done = 1'b1;
        end
      end
    end
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  int exp_seq[13] = '{1, 2, 3, 4, 5, 6, 3, 4, 5, 6, 7, 8, 9};
  int exp_rin[3]  = '{2, 1, 0};
  int prog, nw;

  initial begin : stim
    rst = 1'b0; start_pause = 1'b0; mode_next = 1'b0; weight_next = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);

    chk("model_len_mode0", seg_count(0), 13);
    chk("model_fill_w3", seg_dur(0, 3, 0), 8);
    chk("reset_ctrl", int'({running, paused, light_xi, light_piao, light_tuo,
                            valve_in, valve_out, motor, buzzer}), 0);
    chk("reset_phase", int'(phase), 0);
    chk("reset_rem", int'(rem_sec), 0);
    chk("reset_rinse", int'(rinse_left), 0);
    chk("reset_status", int'({status_mode, status_weight}), 0);

    pulse_mode(7);
    chk("mode_wrap", int'(status_mode), 1);
    pulse_mode(5);

    // Full program, with an ignored weight_next during FILL_W
    watch(1, 200);
    prog = 0;
    for (int p = 1; p <= 8; p++) prog += pcnt[p];
    chk("full_prog_cycles", prog, 88);
    chk("full_done_cycles", pcnt[9], 8);
    chk("full_buzz_cycles", buzz_cyc, 8);
    chk("full_seq_len", pseq.size(), 13);
    if (pseq.size() == 13)
      for (int i = 0; i < 13; i++) chk("full_seq_elem", pseq[i], exp_seq[i]);
    chk("full_rinse_len", rseq.size(), 3);
    if (rseq.size() == 3)
      for (int i = 0; i < 3; i++) chk("full_rinse_elem", rseq[i], exp_rin[i]);
    chk("weight_ignored", int'(status_weight), 0);

    // Weight scaling, spin-only program
    pulse_mode(5);
    pulse_weight(3);
    chk("setup_mode5", int'(status_mode), 5);
    chk("setup_weight3", int'(status_weight), 3);
    watch(0, 200);
    chk("w3_drain_s_cycles", pcnt[7], 16);
    chk("w3_spin_cycles", pcnt[8], 8);
    chk("tuo_during_spin", int'(tuo_spin), 1);
    chk("tuo_after_spin", int'(tuo_exit), 0);

    // Pause during WASH, wash-only program
    pulse_mode(3);
    watch(2, 200);
    chk("pause_wash_cycles", pcnt[2], 22);
    chk("pause_len", pause_cyc, 10);
    chk("pause_fill_cycles", pcnt[1], 32);

    // Start and mode_next in the same cycle, then asynchronous reset in RINSE
    pulse_mode(2);
    start_pause = 1'b1; mode_next = 1'b1;
    @(negedge clk);
    start_pause = 1'b0; mode_next = 1'b0;
    chk("start_wins_mode", int'(status_mode), 4);
    chk("start_first_phase", int'(phase), 3);
    chk("start_rinse_left", int'(rinse_left), 1);
    nw = 0;
    while (phase != 4'd6 && nw < 100) begin
      @(negedge clk); nw++;
    end
    chk("reach_rinse", int'(phase), 6);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_act", int'({valve_in, valve_out, motor, buzzer}), 0);
    chk("async_rst_phase", int'(phase), 0);
    chk("async_rst_running", int'(running), 0);
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);

    // Random front-panel activity checked by the per-cycle comparison
    for (int c = 0; c < 3000; c++) begin
      start_pause = ($urandom_range(0, 39) == 0);
      mode_next   = ($urandom_range(0, 11) == 0);
      weight_next = ($urandom_range(0, 11) == 0);
      @(negedge clk);
    end
    start_pause = 1'b0; mode_next = 1'b0; weight_next = 1'b0;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
